// File: rtl/tof_result_reader_if.sv
// Pixel-stream handshake between a ToF result reader and its frame source and sink.
interface tof_result_reader_if #(
  parameter int NP        = 16,
  parameter int PIXEL_NUM = 4
);
  localparam int PW = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;

  logic                    frameDone;
  logic [NP*PIXEL_NUM-1:0] result;
  logic                    outReady;
  logic                    outValid;
  logic [NP-1:0]           outData;
  logic [PW-1:0]           outPixel;
  logic                    outLast;

  modport master (
    output frameDone, result, outReady,
    input  outValid, outData, outPixel, outLast
  );

  modport slave (
    input  frameDone, result, outReady,
    output outValid, outData, outPixel, outLast
  );
endinterface

// File: rtl/tof_result_reader.sv
// Serialises packed per-pixel peak results into a ready/valid word stream,
// with one frame of look-ahead buffering and a sticky drop flag.
module tof_result_reader #(
  parameter int NP        = 16,
  parameter int PIXEL_NUM = 4
) (
  input  logic                clk,
  input  logic                res,
  tof_result_reader_if.slave  bus,
  output logic                busy,
  output logic                overflow,
  output logic [15:0]         frameCount
);
  localparam int PW = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(PIXEL_NUM - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                       state, state_nxt;
  logic [PIXEL_NUM-1:0][NP-1:0] active, pending;
  logic                         pend_full;
  logic [PW-1:0]                idx;
  logic                         streaming, last_pix, xfer, last_xfer;

  assign streaming = (state == S_STREAM);
  assign last_pix  = (idx == LAST_IDX);
  assign xfer      = streaming && bus.outReady;
  assign last_xfer = xfer && last_pix;

  always_ff @(posedge clk) begin
    if (res) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.frameDone) state_nxt = S_STREAM;
      S_STREAM: if (last_xfer && !pend_full && !bus.frameDone) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.outValid = streaming;
    bus.outData  = active[idx];
    bus.outPixel = idx;
    bus.outLast  = last_pix;
    busy         = streaming || pend_full;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      active     <= '0;
      pending    <= '0;
      pend_full  <= 1'b0;
      idx        <= '0;
      overflow   <= 1'b0;
      frameCount <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.frameDone) begin
            active     <= bus.result;
            idx        <= '0;
            frameCount <= frameCount + 16'd1;
          end
        end
        S_STREAM: begin
          if (xfer && !last_pix) idx <= idx + PW'(1);
          if (last_xfer) begin
            idx <= '0;
            // The last word frees a slot, so a coincident frameDone is never dropped.
            if (pend_full) begin
              active <= pending;
              if (bus.frameDone) begin
                pending    <= bus.result;
                frameCount <= frameCount + 16'd1;
              end else begin
                pend_full <= 1'b0;
              end
            end else if (bus.frameDone) begin
              // Equivalent to staging through pending, minus the extra cycle.
              active     <= bus.result;
              frameCount <= frameCount + 16'd1;
            end
          end else if (bus.frameDone) begin
            if (!pend_full) begin
              pending    <= bus.result;
              pend_full  <= 1'b1;
              frameCount <= frameCount + 16'd1;
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/tof_result_reader.md
TOF_RESULT_READER -- requirements
Module: tof_result_reader

Interface
REQ-001 Parameter NP, 16, bit width of one pixel peak result.
REQ-002 Parameter PIXEL_NUM, 4, pixels per packed result bus; legal range 2..200.
REQ-003 Parameter PW, derived as clog2(PIXEL_NUM) with a minimum of 1, width of the pixel index.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 res  in  1  reset, synchronous and active-high.
REQ-006 frameDone  in  1  one-cycle pulse: the result bus holds a complete frame this cycle.
REQ-007 result  in  NP*PIXEL_NUM  packed peak results; pixel k occupies bits [k*NP +: NP].
REQ-008 outReady  in  1  downstream accepts outData this cycle.
REQ-009 outValid  out  1  outData, outPixel and outLast are valid.
REQ-010 outData  out  NP  peak result of the current pixel.
REQ-011 outPixel  out  PW  index of the current pixel, 0..PIXEL_NUM-1.
REQ-012 outLast  out  1  current word is pixel PIXEL_NUM-1.
REQ-013 busy  out  1  high when in STREAM or when the pending buffer is full.
REQ-014 overflow  out  1  sticky: a frame was dropped.
REQ-015 frameCount  out  16  count of frames accepted into a buffer, modulo 2^16.

Function
REQ-016 Storage: one active buffer (the frame being streamed) and one pending buffer, each NP*PIXEL_NUM bits, plus a pending-full flag.
REQ-017 FSM states: IDLE (outValid=0) and STREAM (outValid=1).
REQ-018 IDLE with frameDone=1: capture result into the active buffer, set pixel index to 0, enter STREAM; outValid is high the next cycle (latency 1).
REQ-019 Transfer: occurs on any cycle where outValid && outReady; no other event advances the stream.
REQ-020 When outValid=1 and outReady=0, outData, outPixel and outLast hold their values.
REQ-021 outData = active[outPixel*NP +: NP]; outLast = (outPixel == PIXEL_NUM-1).
REQ-022 Non-last transfer: increment the pixel index by 1 and stay in STREAM.
REQ-023 Last transfer with pending full: copy pending into active, clear pending-full, reset the index to 0, stay in STREAM; the next word is valid the following cycle with no bubble.
REQ-024 Last transfer with pending empty and no frameDone: return to IDLE, which drops outValid the next cycle.
REQ-025 frameDone in STREAM with pending empty: capture result into pending and set pending-full. This includes the cycle of the last transfer; in that case the new frame streams next with no bubble.
REQ-026 frameDone in STREAM with pending full and no last transfer in the same cycle: drop the new frame, set overflow, and leave frameCount unchanged.
REQ-027 frameDone in STREAM with pending full on the cycle of the last transfer: pending moves to active and the new result goes into pending; no drop occurs.
REQ-028 frameCount increments by 1 on every captured frame (REQ-018, REQ-025, REQ-027) and wraps from 0xFFFF to 0.
REQ-029 overflow stays set until reset.

Reset
REQ-030 When res=1 at a rising edge, the block enters IDLE with: outValid=0, outData=0, outPixel=0, outLast=0, busy=0, overflow=0, frameCount=0, pending-full=0, both buffers zero.
REQ-031 res has priority over frameDone and transfers in the same cycle; a frame in progress when reset is asserted is discarded, with no partial output after reset.
REQ-032 The first frameDone after res deasserts is handled per REQ-018.

Verification (NP=16, PIXEL_NUM=4)
REQ-033 result=0x0004_0003_0002_0001, frameDone at t, outReady=1 -> words 0x0001..0x0004 with outPixel 0..3 at t+1..t+4; outLast=1 only at t+4; outValid=0 at t+5; frameCount=1.
REQ-034 Same frame with outReady toggled 1,0,0,1,... -> the word is held while outReady=0; sequence 1,2,3,4 is unchanged, with no duplicates and no gaps.
REQ-035 Frame A streaming with outReady=0; frameDone with B, then frameDone with C -> B is pending and C is dropped; overflow=1; frameCount=2; after release the output is A then B, back-to-back.
REQ-036 frameDone with B on the cycle of A's last transfer -> B pixel 0 is valid the next cycle with no bubble; frameCount=2; overflow=0.
REQ-037 res pulsed while pixel 2 is streaming -> the next cycle has outValid=0, frameCount=0, overflow=0; a new frameDone streams from pixel 0.
REQ-038 65536 frames, each fully drained -> frameCount wraps to 0; overflow=0.
